roller_arbiter: RTL and testbench



---
 rtl/roller_arbiter_if.sv | 34 +++
 rtl/roller_arbiter.sv | 174 +++++++++++++++++
 tb/tb_roller_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roller_arbiter_if.sv
// roller_arbiter_if: bundles the requester side, the roller input port and the
// monitored roller output handshake of the shared-roller arbiter.
// slave  = arbiter side, master = producers/roller/consumer side.
interface roller_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int N_REQ      = 3,
  parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  // requesters
  logic [DATA_WIDTH-1:0] req_data [N_REQ*NUM];
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  // roller input
  logic [DATA_WIDTH-1:0] roll_in_data [NUM];
  logic                  roll_in_valid;
  logic                  roll_in_ready;
  // roller output (monitored) and tags
  logic                  roll_out_valid;
  logic                  roll_out_ready;
  logic [ID_W-1:0]       out_id;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  req_data, req_valid, roll_in_ready, roll_out_valid, roll_out_ready,
    output req_ready, roll_in_data, roll_in_valid, out_id, out_last, busy
  );

  modport master (
    output req_data, req_valid, roll_in_ready, roll_out_valid, roll_out_ready,
    input  req_ready, roll_in_data, roll_in_valid, out_id, out_last, busy
  );
endinterface

// File: rtl/roller_arbiter.sv
// roller_arbiter: round-robin sharing of one vector-to-chunk roller between
// N_REQ producers. One vector is in flight at a time: IDLE arbitrates, LOAD
// forwards the granted vector, DRAIN counts roller output beats and tags them
// with the source id and a last-beat flag.
// Optional statistics (grant_count, stall_cycles): define ROLLER_ARB_STATS_EN.
module roller_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int ROLL_NUM   = 2,
  parameter int N_REQ      = 3,
  parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic clk,
  input  logic rst,
`ifdef ROLLER_ARB_STATS_EN
  output logic [31:0] grant_count [N_REQ],
  output logic [31:0] stall_cycles,
`endif
  roller_arbiter_if.slave bus
);

  localparam int CYCLES = NUM / ROLL_NUM;
  localparam int CNT_W  = $clog2(CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]  pick_hi_s, pick_any_s, pick_s;
  logic             found_hi_s;
  logic             grant_valid_s;
  logic             load_hs_s;
  logic             out_hs_s;

  assign grant_valid_s = bus.req_valid[grant_q];
  assign load_hs_s     = (state_q == LOAD) && grant_valid_s && bus.roll_in_ready;
  assign out_hs_s      = bus.roll_out_valid && bus.roll_out_ready;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    pick_hi_s  = '0;
    pick_any_s = '0;
    found_hi_s = 1'b0;
    for (int r = N_REQ - 1; r >= 0; r--) begin
      pick_any_s = bus.req_valid[r] ? ID_W'(r) : pick_any_s;
      pick_hi_s  = (bus.req_valid[r] && (ID_W'(r) >= rr_ptr_q)) ? ID_W'(r) : pick_hi_s;
      found_hi_s = found_hi_s | (bus.req_valid[r] && (ID_W'(r) >= rr_ptr_q));
    end
    pick_s = found_hi_s ? pick_hi_s : pick_any_s;
  end

  // Next-state logic and roller-input handshake outputs.
  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    grant_d           = grant_q;
    cur_id_d          = cur_id_q;
    beat_cnt_d        = beat_cnt_q;
    bus.roll_in_valid = 1'b0;
    bus.req_ready     = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d = pick_s;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        bus.roll_in_valid = grant_valid_s;
        for (int r = 0; r < N_REQ; r++) begin
          bus.req_ready[r] = (grant_q == ID_W'(r)) ? bus.roll_in_ready : 1'b0;
        end
        // A dropped valid keeps the grant: no re-arbitration until accepted.
        if (load_hs_s) begin
          cur_id_d   = grant_q;
          beat_cnt_d = '0;
          rr_ptr_d   = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);
          state_d    = DRAIN;
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (out_hs_s) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          state_d    = (beat_cnt_q == LAST_BEAT) ? IDLE : DRAIN;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Roller input vector: combinational mux on the registered grant.
  always_comb begin
    for (int k = 0; k < NUM; k++) begin
      bus.roll_in_data[k] = '0;
    end
    for (int r = 0; r < N_REQ; r++) begin
      for (int k = 0; k < NUM; k++) begin
        bus.roll_in_data[k] = (grant_q == ID_W'(r)) ? bus.req_data[r*NUM + k]
                                                    : bus.roll_in_data[k];
      end
    end
  end

  assign bus.out_id   = cur_id_q;
  assign bus.out_last = (state_q == DRAIN) && (beat_cnt_q == LAST_BEAT);
  assign bus.busy     = (state_q != IDLE);

  // State and arbitration registers; reset aborts any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      cur_id_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cur_id_q   <= cur_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef ROLLER_ARB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] grant_count_q [N_REQ];
  logic [31:0] stall_cycles_q;

  // Per-requester accepted-vector count and consumer-stall cycles while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_REQ; r++) begin
        grant_count_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < N_REQ; r++) begin
        if (load_hs_s && (grant_q == ID_W'(r))) begin
          grant_count_q[r] <= sat_inc32(grant_count_q[r]);
        end
      end
      if ((state_q == DRAIN) && bus.roll_out_valid && !bus.roll_out_ready) begin
        stall_cycles_q <= sat_inc32(stall_cycles_q);
      end
    end
  end

  assign grant_count  = grant_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_roller_arbiter.sv
// tb_roller_arbiter: directed scenarios for roller_arbiter (N_REQ=3, NUM=8,
// ROLL_NUM=2 -> 4 beats per vector). Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_roller_arbiter;
  localparam int DW  = 16;
  localparam int NUM = 8;
  localparam int RN  = 2;
  localparam int NR  = 3;
  localparam int IW  = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  roller_arbiter_if #(.DATA_WIDTH(DW), .NUM(NUM), .N_REQ(NR), .ID_W(IW)) bus ();

`ifdef ROLLER_ARB_STATS_EN
  logic [31:0] grant_count [NR];
  logic [31:0] stall_cycles;
`endif

  roller_arbiter #(
    .DATA_WIDTH(DW), .NUM(NUM), .ROLL_NUM(RN), .N_REQ(NR), .ID_W(IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ROLLER_ARB_STATS_EN
    .grant_count  (grant_count),
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element k of requester r: requester 1 carries 1..8.
  function automatic logic [15:0] elem(input int r, input int k);
    case (r)
      0:       return 16'h0A00 + 16'(k);
      1:       return 16'(k + 1);
      default: return 16'h0C00 + 16'(k);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid      = 3'b000;
    bus.roll_in_ready  = 1'b1;
    bus.roll_out_valid = 1'b0;
    bus.roll_out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    bus.req_valid = 3'b111;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b expected 0", bus.busy); end
    total++; if (bus.roll_in_valid !== 1'b0) begin bad++; $display("FAIL rst_roll_in_valid: got %0b expected 0", bus.roll_in_valid); end
    total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL rst_req_ready: got %0b expected 000", bus.req_ready); end
    total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL rst_out_id: got %0d expected 0", bus.out_id); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %0b expected 0", bus.out_last); end
    step();
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_dominates_req: got %0b expected 0", bus.busy); end
    bus.req_valid = 3'b000;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int pulses;
    pulses = 0;
    bus.req_valid = 3'b010;
    @(negedge clk);
    total++; if (bus.roll_in_valid !== 1'b0) begin bad++; $display("FAIL single_latency: got %0b expected 0", bus.roll_in_valid); end
    pulses += int'(bus.req_ready[1]);
    step();
    @(negedge clk);
    total++; if (bus.roll_in_valid !== 1'b1) begin bad++; $display("FAIL single_roll_in_valid: got %0b expected 1", bus.roll_in_valid); end
    total++; if (bus.req_ready !== 3'b010) begin bad++; $display("FAIL single_req_ready: got %0b expected 010", bus.req_ready); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b expected 1", bus.busy); end
    for (int k = 0; k < NUM; k++) begin
      total++; if (bus.roll_in_data[k] !== elem(1, k)) begin bad++; $display("FAIL single_data[%0d]: got %0h expected %0h", k, bus.roll_in_data[k], elem(1, k)); end
    end
    pulses += int'(bus.req_ready[1]);
    step();
    bus.req_valid      = 3'b000;
    bus.roll_out_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      total++; if (bus.out_id !== 2'd1) begin bad++; $display("FAIL single_out_id beat %0d: got %0d expected 1", b, bus.out_id); end
      total++; if (bus.out_last !== (b == 3)) begin bad++; $display("FAIL single_out_last beat %0d: got %0b expected %0b", b, bus.out_last, (b == 3)); end
      total++; if (bus.roll_in_valid !== 1'b0) begin bad++; $display("FAIL single_drain_roll_in_valid: got %0b expected 0", bus.roll_in_valid); end
      pulses += int'(bus.req_ready[1]);
      step();
    end
    bus.roll_out_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_back_idle: got %0b expected 0", bus.busy); end
    pulses += int'(bus.req_ready[1]);
    total++; if (pulses !== 1) begin bad++; $display("FAIL single_ready_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    logic [2:0] exp_rdy;
    do_reset();
    bus.req_valid = 3'b111;
    for (int v = 0; v < 6; v++) begin
      exp_id  = 2'(v % 3);
      exp_rdy = 3'b001 << exp_id;
      @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_idle vec %0d: got %0b expected 0", v, bus.busy); end
      step();
      @(negedge clk);
      total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant vec %0d: got %0b expected %0b", v, bus.req_ready, exp_rdy); end
      total++; if (bus.roll_in_data[0] !== elem(int'(exp_id), 0)) begin bad++; $display("FAIL rr_data0 vec %0d: got %0h expected %0h", v, bus.roll_in_data[0], elem(int'(exp_id), 0)); end
      total++; if (bus.roll_in_data[NUM-1] !== elem(int'(exp_id), NUM-1)) begin bad++; $display("FAIL rr_data7 vec %0d: got %0h expected %0h", v, bus.roll_in_data[NUM-1], elem(int'(exp_id), NUM-1)); end
      step();
      bus.roll_out_valid = 1'b1;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        total++; if (bus.out_id !== exp_id) begin bad++; $display("FAIL rr_out_id vec %0d beat %0d: got %0d expected %0d", v, b, bus.out_id, exp_id); end
        total++; if (bus.out_last !== (b == 3)) begin bad++; $display("FAIL rr_out_last vec %0d beat %0d: got %0b expected %0b", v, b, bus.out_last, (b == 3)); end
        total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL rr_drain_ready vec %0d: got %0b expected 000", v, bus.req_ready); end
        step();
      end
      bus.roll_out_valid = 1'b0;
    end
    bus.req_valid = 3'b000;
`ifdef ROLLER_ARB_STATS_EN
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      total++; if (grant_count[r] !== 32'd2) begin bad++; $display("FAIL rr_grant_count[%0d]: got %0d expected 2", r, grant_count[r]); end
    end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    bus.req_valid = 3'b001;
    step();
    @(negedge clk);
    total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL stall_grant: got %0b expected 001", bus.req_ready); end
    step();
    bus.req_valid      = 3'b010;
    bus.roll_out_valid = 1'b1;
    bus.roll_out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL stall_pre_last beat %0d: got %0b expected 0", b, bus.out_last); end
      step();
    end
    bus.roll_out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stall_busy cyc %0d: got %0b expected 1", s, bus.busy); end
      total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL stall_hold_last cyc %0d: got %0b expected 0", s, bus.out_last); end
      total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL stall_no_grant cyc %0d: got %0b expected 000", s, bus.req_ready); end
      total++; if (bus.roll_in_valid !== 1'b0) begin bad++; $display("FAIL stall_roll_in_valid cyc %0d: got %0b expected 0", s, bus.roll_in_valid); end
      step();
    end
    bus.roll_out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL stall_beat3_last: got %0b expected 0", bus.out_last); end
    step();
    @(negedge clk);
    total++; if (bus.out_last !== 1'b1) begin bad++; $display("FAIL stall_beat4_last: got %0b expected 1", bus.out_last); end
    total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL stall_out_id: got %0d expected 0", bus.out_id); end
    step();
    bus.roll_out_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stall_back_idle: got %0b expected 0", bus.busy); end
`ifdef ROLLER_ARB_STATS_EN
    total++; if (stall_cycles !== 32'd5) begin bad++; $display("FAIL stall_cycles: got %0d expected 5", stall_cycles); end
`endif
    step();
    @(negedge clk);
    total++; if (bus.req_ready !== 3'b010) begin bad++; $display("FAIL stall_next_grant: got %0b expected 010", bus.req_ready); end
    bus.req_valid = 3'b000;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.roll_in_ready = 1'b0;
    bus.req_valid     = 3'b100;
    step();
    bus.req_valid = 3'b101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.roll_in_valid !== 1'b1) begin bad++; $display("FAIL bp_roll_in_valid cyc %0d: got %0b expected 1", c, bus.roll_in_valid); end
      total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL bp_req_ready cyc %0d: got %0b expected 000", c, bus.req_ready); end
      total++; if (bus.roll_in_data[0] !== elem(2, 0)) begin bad++; $display("FAIL bp_data cyc %0d: got %0h expected %0h", c, bus.roll_in_data[0], elem(2, 0)); end
      step();
    end
    bus.req_valid     = 3'b001;
    bus.roll_in_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.roll_in_valid !== 1'b0) begin bad++; $display("FAIL bp_drop_valid: got %0b expected 0", bus.roll_in_valid); end
    total++; if (bus.req_ready !== 3'b100) begin bad++; $display("FAIL bp_drop_keep_grant: got %0b expected 100", bus.req_ready); end
    step();
    bus.req_valid = 3'b101;
    @(negedge clk);
    total++; if (bus.roll_in_valid !== 1'b1) begin bad++; $display("FAIL bp_resume_valid: got %0b expected 1", bus.roll_in_valid); end
    total++; if (bus.req_ready !== 3'b100) begin bad++; $display("FAIL bp_resume_ready: got %0b expected 100", bus.req_ready); end
    step();
    bus.req_valid      = 3'b001;
    bus.roll_out_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      total++; if (bus.out_id !== 2'd2) begin bad++; $display("FAIL bp_out_id beat %0d: got %0d expected 2", b, bus.out_id); end
      step();
    end
    bus.roll_out_valid = 1'b0;
    bus.req_valid      = 3'b111;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_back_idle: got %0b expected 0", bus.busy); end
    step();
    @(negedge clk);
    total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL bp_rr_ptr_wrap: got %0b expected 001", bus.req_ready); end
    total++; if (bus.roll_in_data[0] !== elem(0, 0)) begin bad++; $display("FAIL bp_next_data: got %0h expected %0h", bus.roll_in_data[0], elem(0, 0)); end
    bus.req_valid = 3'b000;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    bus.req_valid = 3'b001;
    step();
    step();
    bus.req_valid      = 3'b011;
    bus.roll_out_valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.roll_out_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b expected 0", bus.busy); end
    total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL mid_rst_req_ready: got %0b expected 000", bus.req_ready); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL mid_rst_out_last: got %0b expected 0", bus.out_last); end
    total++; if (bus.roll_in_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_roll_in_valid: got %0b expected 0", bus.roll_in_valid); end
    step();
    @(negedge clk);
    total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL mid_rst_first_grant: got %0b expected 001", bus.req_ready); end
    total++; if (bus.roll_in_valid !== 1'b1) begin bad++; $display("FAIL mid_rst_load_valid: got %0b expected 1", bus.roll_in_valid); end
`ifdef ROLLER_ARB_STATS_EN
    total++; if (grant_count[0] !== 32'd0) begin bad++; $display("FAIL mid_rst_grant_count: got %0d expected 0", grant_count[0]); end
`endif
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < NUM; k++) begin
        bus.req_data[r*NUM + k] = elem(r, k);
      end
    end
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
